ysyx_25040118_ifu: RTL and testbench

Instruction fetch unit directly upstream of the decode stage. It owns the PC and issues one-at-a-time word fetches over a valid/ready request plus response-valid instruction-memory interface. It registers each returned instruction with its PC into a one-entry output slot, handed to decode via a valid/ready handshake. It also accepts PC redirects from execute and stops fetching on halt (ebreak) or a fetch error.

---
 rtl/ysyx_25040118_ifu_if.sv | 24 ++
 rtl/ysyx_25040118_ifu.sv | 136 +++++++++++++
 tb/tb_ysyx_25040118_ifu.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040118_ifu_if.sv
// Fetch-side bundle: instruction-memory request/response channel plus the decode-facing inst channel.
// master = fetch unit, slave = memory/decode environment.
interface ysyx_25040118_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
    );
endinterface

// File: rtl/ysyx_25040118_ifu.sv
// Fetch unit: one outstanding word fetch, one-entry output slot; 3 cycles/inst with zero-wait memory.
// Backpressure: slot holds inst/inst_pc until decode takes it; no new request is issued meanwhile.
module ysyx_25040118_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_25040118_ifu_if.master     bus,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    input  logic                    halt,
    output logic                    halted,
    output logic                    fetch_fault
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DELIVER = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        drop_q, drop_d;
    logic        halt_pend_q, halt_pend_d;
    logic        fault_q, fault_d;
    logic [31:0] target;

    assign target = redirect_pc & ~32'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            drop_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            drop_q      <= drop_d;
            halt_pend_q <= halt_pend_d;
            fault_q     <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        drop_d      = drop_q;
        halt_pend_d = halt_pend_q;
        fault_d     = fault_q;

        case (state_q)
            FETCH: begin
                // An accepted request must still be waited out, so halt/redirect become pending.
                if (halt) begin
                    if (bus.imem_req_ready) begin
                        halt_pend_d = 1'b1;
                        state_d     = WAIT;
                    end else begin
                        state_d = HALT;
                    end
                end else if (redirect_valid) begin
                    pc_d = target;
                    if (bus.imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (halt) begin
                    halt_pend_d = 1'b1;
                end else if (redirect_valid) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    if (halt || halt_pend_q) begin
                        state_d = HALT;
                    end else if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = FETCH;
                    end else if (bus.imem_rsp_err) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        inst_d    = bus.imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = DELIVER;
                    end
                end
            end

            DELIVER: begin
                // Redirect beats a same-cycle handshake: the slot is flushed, no PC step.
                if (halt) begin
                    state_d = HALT;
                end else if (redirect_valid) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = HALT;
            end
        endcase
    end

    assign bus.imem_req_valid = (state_q == FETCH);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (state_q == DELIVER);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign halted             = (state_q == HALT);
    assign fetch_fault        = fault_q;

endmodule

// File: tb/tb_ysyx_25040118_ifu.sv
// Bench for the fetch unit: behavioural instruction memory with programmable latency/fault,
// scoreboard of expected (pc, inst) pairs popped on every decode handshake.
module tb_ysyx_25040118_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic        halted;
    logic        fetch_fault;

    ysyx_25040118_ifu_if bus ();

    ysyx_25040118_ifu #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    int          mem_lat = 1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    exp_t        sb[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == RESET_PC) ? 32'h0010_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    function automatic void push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.inst = mem_word(a);
        sb.push_back(e);
    endfunction

    // Instruction memory: acceptance sampled mid-cycle, response driven just after the edge.
    initial begin
        logic        acc, r, pend;
        logic [31:0] a, paddr;
        int          cnt;
        pend = 1'b0; cnt = 0; paddr = '0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            acc = (bus.imem_req_valid === 1'b1) && bus.imem_req_ready && !rst;
            a   = bus.imem_req_addr;
            r   = rst;
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
            if (r) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend = 1'b1; cnt = mem_lat; paddr = a;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = mem_word(paddr);
                        bus.imem_rsp_err   = err_en && (paddr == err_addr);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard: a handshake counts only when no redirect/halt/reset overrides it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1 && bus.inst_ready && !redirect_valid && !halt && !rst) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got pc=%h inst=%h, required no delivery", bus.inst_pc, bus.inst);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst !== e.inst) begin
                        fails++;
                        $display("FAIL sb_data: got pc=%h inst=%h, required pc=%h inst=%h",
                                 bus.inst_pc, bus.inst, e.pc, e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_sb_empty(input int bound, output int n);
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            cyc();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d entries left after %0d cycles, required 0", sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        bus.inst_ready = 1'b0;
        do_reset();
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1) begin fails++; $display("FAIL reset_req_valid: got %b, required 1", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h, required %h", bus.imem_req_addr, RESET_PC); end
        checks++; if (bus.inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b, required 0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h/%h, required 0/0", bus.inst, bus.inst_pc); end
        checks++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin fails++; $display("FAIL reset_flags: got halted=%b fault=%b, required 0/0", halted, fetch_fault); end
    endtask

    task automatic test_basic();
        mem_lat = 1;
        bus.inst_ready = 1'b1;
        push_exp(RESET_PC);
        do_reset();
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin fails++; $display("FAIL basic_c1_req: got v=%b a=%h, required 1/%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC); end
        cyc(); @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL basic_c2_wait: got req=%b inst_valid=%b, required 0/0", bus.imem_req_valid, bus.inst_valid); end
        cyc(); @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== 32'h0010_0093 || bus.inst_pc !== RESET_PC) begin fails++; $display("FAIL basic_c3_inst: got v=%b inst=%h pc=%h, required 1/00100093/%h", bus.inst_valid, bus.inst, bus.inst_pc, RESET_PC); end
        cyc(); @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC + 32'd4) begin fails++; $display("FAIL basic_next_req: got v=%b a=%h, required 1/%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC + 32'd4); end
        cyc();
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        mem_lat = 1;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_exp(RESET_PC + 32'(4 * k));
        do_reset();
        wait_sb_empty(60, n);
        checks++; if (n != 15) begin fails++; $display("FAIL b2b_cycles: got %0d cycles for 5 insts, required 15", n); end
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_inst, hold_pc;
        int          n;
        bit          found;
        mem_lat = 1;
        bus.inst_ready = 1'b0;
        push_exp(RESET_PC);
        push_exp(RESET_PC + 32'd4);
        do_reset();
        found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) begin found = 1; break; end
            cyc();
        end
        checks++; if (!found) begin fails++; $display("FAIL bp_deliver: got no inst_valid in 10 cycles, required delivery"); end
        hold_inst = bus.inst;
        hold_pc   = bus.inst_pc;
        for (int i = 0; i < 5; i++) begin
            cyc(); @(negedge clk);
            checks++;
            if (bus.inst !== hold_inst || bus.inst_pc !== hold_pc || bus.inst_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold: got inst=%h pc=%h v=%b req=%b, required %h/%h/1/0", bus.inst, bus.inst_pc, bus.inst_valid, bus.imem_req_valid, hold_inst, hold_pc);
            end
        end
        cyc();
        bus.inst_ready = 1'b1;
        cyc(); @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC + 32'd4) begin fails++; $display("FAIL bp_pc_step: got v=%b a=%h, required 1/%h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC + 32'd4); end
        wait_sb_empty(20, n);
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        int n;
        bit seen_inst, found;
        mem_lat = 3;
        bus.inst_ready = 1'b1;
        push_exp(32'h8000_0100);
        do_reset();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL rw_in_wait: got req=%b, required 0", bus.imem_req_valid); end
        cyc();
        redirect_valid = 1'b0;
        seen_inst = 0; found = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.inst_valid === 1'b1) seen_inst = 1;
            if (bus.imem_req_valid === 1'b1) begin found = 1; break; end
            cyc();
        end
        checks++; if (seen_inst || !found) begin fails++; $display("FAIL rw_discard: got inst_seen=%b refetch=%b, required 0/1", seen_inst, found); end
        checks++; if (bus.imem_req_addr !== 32'h8000_0100) begin fails++; $display("FAIL rw_addr: got %h, required 80000100", bus.imem_req_addr); end
        cyc();
        wait_sb_empty(20, n);
        bus.inst_ready = 1'b0;
        mem_lat = 1;
    endtask

    task automatic test_redirect_deliver();
        int n;
        mem_lat = 1;
        bus.inst_ready = 1'b1;
        push_exp(32'h8000_0040);
        do_reset();
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b1) begin fails++; $display("FAIL rd_in_deliver: got inst_valid=%b, required 1", bus.inst_valid); end
        cyc();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0040) begin fails++; $display("FAIL rd_addr: got v=%b a=%h, required 1/80000040", bus.imem_req_valid, bus.imem_req_addr); end
        wait_sb_empty(20, n);
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_halt_wait();
        int req_cnt;
        mem_lat = 3;
        bus.inst_ready = 1'b0;
        do_reset();
        cyc();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        @(negedge clk);
        checks++; if (halted !== 1'b0) begin fails++; $display("FAIL hw_pending_c3: got halted=%b, required 0", halted); end
        cyc(); @(negedge clk);
        checks++; if (halted !== 1'b0) begin fails++; $display("FAIL hw_rsp_cycle: got halted=%b, required 0", halted); end
        cyc(); @(negedge clk);
        checks++; if (halted !== 1'b1 || bus.inst_valid !== 1'b0) begin fails++; $display("FAIL hw_halted: got halted=%b inst_valid=%b, required 1/0", halted, bus.inst_valid); end
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); @(negedge clk);
            if (bus.imem_req_valid !== 1'b0) req_cnt++;
        end
        checks++; if (req_cnt != 0) begin fails++; $display("FAIL hw_no_req: got %0d request cycles, required 0", req_cnt); end
        mem_lat = 1;
        do_reset();
        @(negedge clk);
        checks++; if (halted !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin fails++; $display("FAIL hw_restart: got halted=%b v=%b a=%h, required 0/1/%h", halted, bus.imem_req_valid, bus.imem_req_addr, RESET_PC); end
    endtask

    task automatic test_fetch_err();
        mem_lat  = 1;
        err_en   = 1'b1;
        err_addr = RESET_PC;
        bus.inst_ready = 1'b1;
        do_reset();
        cyc();
        cyc();
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b1 || halted !== 1'b1) begin fails++; $display("FAIL err_flags: got fault=%b halted=%b, required 1/1", fetch_fault, halted); end
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin fails++; $display("FAIL err_quiet: got inst_valid=%b req=%b, required 0/0", bus.inst_valid, bus.imem_req_valid); end
        err_en = 1'b0;
        bus.inst_ready = 1'b0;
    endtask

    task automatic test_pc_wrap();
        int n;
        mem_lat = 1;
        bus.imem_req_ready = 1'b0;
        bus.inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (fetch_fault !== 1'b0) begin fails++; $display("FAIL wrap_fault_clr: got %b, required 0", fetch_fault); end
        cyc();
        redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        push_exp(32'hFFFF_FFFC);
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_redirect: got v=%b a=%h, required 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr); end
        wait_sb_empty(20, n);
        @(negedge clk);
        checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin fails++; $display("FAIL wrap_zero: got v=%b a=%h, required 1/00000000", bus.imem_req_valid, bus.imem_req_addr); end
        cyc();
        bus.inst_ready = 1'b0;
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_redirect_wait();
        test_redirect_deliver();
        test_halt_wait();
        test_fetch_err();
        test_pc_wrap();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
